// File: rtl/div_pkg.sv
// div_pkg: shared op/state encodings and default width for the divider
package div_pkg;
  localparam int XLEN_DEFAULT = 32;
  typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FINISH = 2'b10} state_e;
endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: turns the unsigned quotient/remainder into the RISC-V result
module div_sign_fix
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] rem,
  input  logic            neg_a,
  input  logic            neg_b,
  input  logic            dz,
  input  op_e             op,
  output logic [XLEN-1:0] result
);
  logic [XLEN-1:0] q, r;
  // divide-by-zero keeps the all-ones quotient; remainder follows the dividend sign
  always_comb begin
    q = ((neg_a ^ neg_b) && !dz) ? -quo : quo;
    r = neg_a ? -rem : rem;
    result = (op == OP_REM || op == OP_REMU) ? r : q;
  end
endmodule

// File: rtl/riscv_div_unit.sv
// riscv_div_unit: iterative radix-2 RV32M divider; DIV_FAST_SPECIAL_EN short-cuts divide-by-zero and signed overflow
module riscv_div_unit
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  state_e          state;
  op_e             op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo, rem, dvs, abs_a, abs_b, fixed;
  logic            neg_a, neg_b, dz, sgn_in, neg_a_in, neg_b_in, dz_in, fast, ge;
  logic [XLEN:0]   sh, diff;
  // operand conditioning at acceptance and one restoring step
  always_comb begin
    sgn_in = !op[0];
    neg_a_in = sgn_in & dividend[XLEN-1];
    neg_b_in = sgn_in & divisor[XLEN-1];
    abs_a = neg_a_in ? -dividend : dividend;
    abs_b = neg_b_in ? -divisor : divisor;
    dz_in = divisor == '0;
    sh = {rem, quo[XLEN-1]};
    diff = sh - {1'b0, dvs};
    ge = !diff[XLEN];
  end
`ifdef DIV_FAST_SPECIAL_EN
  assign fast = dz_in | (sgn_in & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor));
`else
  assign fast = 1'b0;
`endif
  div_sign_fix #(.XLEN(XLEN)) u_fix (
    .quo(quo), .rem(rem), .neg_a(neg_a), .neg_b(neg_b), .dz(dz), .op(op_q), .result(fixed)
  );
  // control FSM with shift-subtract datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      op_q <= OP_DIV;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      dz <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_q <= op_e'(op);
          neg_a <= neg_a_in;
          neg_b <= neg_b_in;
          dz <= dz_in;
          dvs <= abs_b;
          quo <= (fast && dz_in) ? '1 : abs_a;
          rem <= (fast && dz_in) ? abs_a : '0;
          cnt <= '0;
          state <= fast ? FINISH : CALC;
          busy <= !fast;
        end
        CALC: begin
          rem <= ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
          quo <= {quo[XLEN-2:0], ge};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(XLEN-1)) begin
            state <= FINISH;
            busy <= 1'b0;
          end
        end
        FINISH: begin
          result <= fixed;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
